// File: rtl/inst_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes,
// opcode constants, FSM state encoding and an immediate range helper.
package inst_enc_pkg;

    // Format selector codes carried on in_fmt
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_LI  = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    // RV32I major opcodes
    localparam logic [6:0] OP_ITYPE_A     = 7'h13;
    localparam logic [6:0] OP_UTYPE_LUI   = 7'h37;
    localparam logic [6:0] OP_UTYPE_AUIPC = 7'h17;
    localparam logic [6:0] OP_BTYPE       = 7'h63;
    localparam logic [6:0] OP_STYPE       = 7'h23;
    localparam logic [6:0] OP_JTYPE       = 7'h6F;

    // Output-stage occupancy: FULL_LI holds a LUI with an ADDI still to come
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_FULL_LI = 2'd2
    } state_e;

    // True when v is representable as an nbits-wide two's-complement value,
    // i.e. all bits from nbits-1 upward are copies of the sign.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (nbits - 32'd1);
        return ((v & mask) == 32'h0000_0000) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/inst_enc_if.sv
// Request/response bundle between an instruction producer and inst_enc.
interface inst_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    // Producer/consumer side (drives requests, accepts words)
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    // Encoder side
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/inst_enc_pack.sv
// Combinational RV32I field packer: format + fields -> instruction word and
// an error flag when the immediate cannot be represented. The word is always
// produced, truncating the immediate where it does not fit.
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    // Bit placement and range check per format
    always_comb begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
        err  = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: begin
                inst = {funct7, rs2, rs1, funct3, rd, opcode};
                err  = 1'b0;
            end
            FMT_I: begin
                inst = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !sext_fits(imm, 32'd12);
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !sext_fits(imm, 32'd12);
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !sext_fits(imm, 32'd13) || imm[0];
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode};
                err  = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !sext_fits(imm, 32'd21) || imm[0];
            end
            default: begin
                // Reserved code, or LI reaching the packer unexpanded
                inst = {funct7, rs2, rs1, funct3, rd, opcode};
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_enc.sv
// RV32I instruction encoder with a one-entry registered output stage.
// LI is expanded to ADDI, or LUI followed by an optional ADDI; while the
// second word is pending, new requests are held off.
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter logic LI_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    inst_enc_if.slave  bus
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic        out_valid_r;
    logic [31:0] out_inst_r;
    logic        out_err_r;
    logic [4:0]  li_rd_r;
    logic [11:0] li_lo_r;

    logic        accept_s;
    logic        fire_s;
    logic        load_s;
    logic        li_sel_s;
    logic        li_small_s;
    logic        li_two_s;
    logic [19:0] li_hi_s;

    logic [2:0]  pk_fmt_s;
    logic [6:0]  pk_opcode_s;
    logic [4:0]  pk_rd_s;
    logic [4:0]  pk_rs1_s;
    logic [4:0]  pk_rs2_s;
    logic [2:0]  pk_funct3_s;
    logic [6:0]  pk_funct7_s;
    logic [31:0] pk_imm_s;
    logic [31:0] pk_inst_s;
    logic        pk_err_s;

    assign bus.in_ready  = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.out_inst  = out_inst_r;
    assign bus.out_err   = out_err_r;

    assign accept_s = bus.in_valid && bus.in_ready;
    assign fire_s   = out_valid_r && bus.out_ready;
    assign load_s   = accept_s || ((state_r == ST_FULL_LI) && fire_s);

    // LI split: hi rounds so that the low part lands in [-2048,2047];
    // adding 0x800 only carries into bit 12 when imm[11] is set.
    assign li_sel_s   = LI_EN && (bus.in_fmt == FMT_LI);
    assign li_small_s = sext_fits(bus.in_imm, 32'd12);
    assign li_hi_s    = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
    assign li_two_s   = li_sel_s && !li_small_s && (bus.in_imm[11:0] != 12'h000);

    // Choose what the packer encodes: pending ADDI, expanded LI, or raw fields
    always_comb begin
        pk_fmt_s    = bus.in_fmt;
        pk_opcode_s = bus.in_opcode;
        pk_rd_s     = bus.in_rd;
        pk_rs1_s    = bus.in_rs1;
        pk_rs2_s    = bus.in_rs2;
        pk_funct3_s = bus.in_funct3;
        pk_funct7_s = bus.in_funct7;
        pk_imm_s    = bus.in_imm;
        if (state_r == ST_FULL_LI) begin
            pk_fmt_s    = FMT_I;
            pk_opcode_s = OP_ITYPE_A;
            pk_rd_s     = li_rd_r;
            pk_rs1_s    = li_rd_r;
            pk_funct3_s = 3'd0;
            pk_imm_s    = {{20{li_lo_r[11]}}, li_lo_r};
        end else if (li_sel_s) begin
            if (li_small_s) begin
                pk_fmt_s    = FMT_I;
                pk_opcode_s = OP_ITYPE_A;
                pk_rs1_s    = 5'd0;
                pk_funct3_s = 3'd0;
            end else begin
                pk_fmt_s    = FMT_U;
                pk_opcode_s = OP_UTYPE_LUI;
                pk_imm_s    = {li_hi_s, 12'h000};
            end
        end else begin
            pk_fmt_s = bus.in_fmt;
        end
    end

    inst_pack u_pack (
        .fmt    (pk_fmt_s),
        .opcode (pk_opcode_s),
        .rd     (pk_rd_s),
        .rs1    (pk_rs1_s),
        .rs2    (pk_rs2_s),
        .funct3 (pk_funct3_s),
        .funct7 (pk_funct7_s),
        .imm    (pk_imm_s),
        .inst   (pk_inst_s),
        .err    (pk_err_s)
    );

    // Next-state logic for output-stage occupancy
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = li_two_s ? ST_FULL_LI : ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fire_s && accept_s) begin
                    state_nxt_s = li_two_s ? ST_FULL_LI : ST_FULL;
                end else if (fire_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_FULL_LI: begin
                if (fire_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_FULL_LI;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, output word and pending-ADDI registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'h0000_0000;
            out_err_r   <= 1'b0;
            li_rd_r     <= 5'd0;
            li_lo_r     <= 12'h000;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            if (load_s) begin
                out_inst_r <= pk_inst_s;
                out_err_r  <= pk_err_s;
            end
            if (accept_s) begin
                li_rd_r <= bus.in_rd;
                li_lo_r <= bus.in_imm[11:0];
            end
        end
    end

endmodule
